// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - two-port I/D-cache to memory arbiter, grant held until mem_resp
// CACHE_ARB_RR_EN: round-robin on contention; undefined gives fixed priority to port 1.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_read,
  input  logic                req0_write,
  input  logic [ADDR_W-1:0]   req0_address,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_byte_enable,
  output logic [DATA_W-1:0]   req0_rdata,
  output logic                req0_resp,
  input  logic                req1_read,
  input  logic                req1_write,
  input  logic [ADDR_W-1:0]   req1_address,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_byte_enable,
  output logic [DATA_W-1:0]   req1_rdata,
  output logic                req1_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp,
  output logic [1:0]          grant,
  output logic                protocol_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE0 = 2'd1, SERVE1 = 2'd2} state_t;

  state_t r_state;
  state_t w_next;
  logic   r_protocol_err;
  logic   w_err_set;
  logic   w_req0;
  logic   w_req1;
  logic   w_pick1;

  assign w_req0 = req0_read | req0_write;
  assign w_req1 = req1_read | req1_write;

`ifdef CACHE_ARB_RR_EN
  logic r_last;

  // On contention the port that was not served last wins.
  assign w_pick1 = w_req1 && (!w_req0 || (r_last == 1'b0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 1'b1;
    end else if (mem_resp && (r_state == SERVE0)) begin
      r_last <= 1'b0;
    end else if (mem_resp && (r_state == SERVE1)) begin
      r_last <= 1'b1;
    end
  end
`else
  assign w_pick1 = w_req1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_protocol_err <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_protocol_err <= r_protocol_err | w_err_set;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        w_err_set = mem_resp;
        if (w_pick1) begin
          w_next = SERVE1;
        end else if (w_req0) begin
          w_next = SERVE0;
        end
      end
      SERVE0: begin
        // Dropping the request or asserting read+write while owning the port is illegal.
        w_err_set = (req0_read & req0_write) | ~w_req0;
        if (mem_resp) begin
          w_next = IDLE;
        end
      end
      SERVE1: begin
        w_err_set = (req1_read & req1_write) | ~w_req1;
        if (mem_resp) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    req0_rdata      = '0;
    req0_resp       = 1'b0;
    req1_rdata      = '0;
    req1_resp       = 1'b0;
    grant           = 2'b00;
    case (r_state)
      SERVE0: begin
        grant           = 2'b01;
        mem_read        = req0_read & ~req0_write;
        mem_write       = req0_write;
        mem_address     = req0_address;
        mem_wdata       = req0_wdata;
        mem_byte_enable = req0_byte_enable;
        req0_rdata      = mem_rdata;
        req0_resp       = mem_resp;
      end
      SERVE1: begin
        grant           = 2'b10;
        mem_read        = req1_read & ~req1_write;
        mem_write       = req1_write;
        mem_address     = req1_address;
        mem_wdata       = req1_wdata;
        mem_byte_enable = req1_byte_enable;
        req1_rdata      = mem_rdata;
        req1_resp       = mem_resp;
      end
      default: ;
    endcase
  end

  assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_read = 1'b0, req0_write = 1'b0;
  logic [31:0] req0_address = '0, req0_wdata = '0;
  logic [3:0]  req0_byte_enable = '0;
  logic [31:0] req0_rdata;
  logic        req0_resp;
  logic        req1_read = 1'b0, req1_write = 1'b0;
  logic [31:0] req1_address = '0, req1_wdata = '0;
  logic [3:0]  req1_byte_enable = '0;
  logic [31:0] req1_rdata;
  logic        req1_resp;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;
  logic [1:0]  grant;
  logic        protocol_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_grant;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_read(req0_read), .req0_write(req0_write), .req0_address(req0_address),
    .req0_wdata(req0_wdata), .req0_byte_enable(req0_byte_enable),
    .req0_rdata(req0_rdata), .req0_resp(req0_resp),
    .req1_read(req1_read), .req1_write(req1_write), .req1_address(req1_address),
    .req1_wdata(req1_wdata), .req1_byte_enable(req1_byte_enable),
    .req1_rdata(req1_rdata), .req1_resp(req1_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .grant(grant), .protocol_err(protocol_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // reset then idle
    repeat (3) tick();
    rst = 1'b1;
    tick(); #1;
    check("rst_grant", grant, 2'b00);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_err", protocol_err, 1'b0);
    check("rst_resp0", req0_resp, 1'b0);

    // single read on port 0
    req0_read = 1'b1; req0_address = 32'h0000_1000; #1;
    check("rd_c0_grant", grant, 2'b00);
    tick(); #1;
    check("rd_c1_grant", grant, 2'b01);
    check("rd_c1_mem_read", mem_read, 1'b1);
    check("rd_c1_addr", mem_address, 32'h0000_1000);
    tick(); tick(); #1;
    check("rd_c3_grant_held", grant, 2'b01);
    tick();
    mem_rdata = 32'hDEAD_BEEF; mem_resp = 1'b1; #1;
    check("rd_c4_resp0", req0_resp, 1'b1);
    check("rd_c4_rdata0", req0_rdata, 32'hDEAD_BEEF);
    check("rd_c4_rdata1", req1_rdata, 32'h0);
    check("rd_c4_resp1", req1_resp, 1'b0);
    tick();
    mem_resp = 1'b0; mem_rdata = '0; req0_read = 1'b0; #1;
    check("rd_c5_grant", grant, 2'b00);

    // write forwarding on port 1
    req1_write = 1'b1; req1_address = 32'h0000_2000;
    req1_wdata = 32'hA5A5_5A5A; req1_byte_enable = 4'b0011;
    tick(); #1;
    check("wr_grant", grant, 2'b10);
    check("wr_mem_write", mem_write, 1'b1);
    check("wr_mem_read", mem_read, 1'b0);
    check("wr_wdata", mem_wdata, 32'hA5A5_5A5A);
    check("wr_be", mem_byte_enable, 4'b0011);
    check("wr_addr", mem_address, 32'h0000_2000);
    mem_resp = 1'b1; #1;
    check("wr_resp1", req1_resp, 1'b1);
    check("wr_resp0", req0_resp, 1'b0);
    tick();
    mem_resp = 1'b0; req1_write = 1'b0; #1;
    check("wr_idle", grant, 2'b00);

    // contention, three rounds; port 1 was served last
    for (int r = 0; r < 3; r++) begin
      req0_read = 1'b1; req0_address = 32'h0000_3000;
      req1_write = 1'b1; req1_address = 32'h0000_4000;
      tick(); #1;
`ifdef CACHE_ARB_RR_EN
      exp_grant = (r % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_grant = 2'b10;
`endif
      check($sformatf("cont_r%0d_grant", r), grant, exp_grant);
      check($sformatf("cont_r%0d_addr", r), mem_address,
            (exp_grant == 2'b01) ? 32'h0000_3000 : 32'h0000_4000);
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0; req0_read = 1'b0; req1_write = 1'b0; #1;
      check($sformatf("cont_r%0d_idle", r), grant, 2'b00);
      tick();
    end
    check("cont_err_clear", protocol_err, 1'b0);

    // read+write together: forwarded as write, error sticky
    req0_read = 1'b1; req0_write = 1'b1; req0_address = 32'h0000_5000;
    tick(); #1;
    check("rw_grant", grant, 2'b01);
    check("rw_mem_write", mem_write, 1'b1);
    check("rw_mem_read", mem_read, 1'b0);
    tick(); #1;
    check("rw_err", protocol_err, 1'b1);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; req0_read = 1'b0; req0_write = 1'b0;
    tick();
    req1_read = 1'b1; req1_address = 32'h0000_5100;
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; req1_read = 1'b0; #1;
    check("rw_err_held", protocol_err, 1'b1);

    // reset mid-transaction in SERVE1
    req1_write = 1'b1; req1_address = 32'h0000_6000;
    tick(); #1;
    check("mid_grant", grant, 2'b10);
    rst = 1'b0; #1;
    check("mid_rst_grant", grant, 2'b00);
    check("mid_rst_mem_write", mem_write, 1'b0);
    check("mid_rst_err", protocol_err, 1'b0);
    tick();
    rst = 1'b1; req1_write = 1'b0;
    req0_read = 1'b1; req0_address = 32'h0000_7000;
    tick(); #1;
    check("post_rst_grant", grant, 2'b01);
    check("post_rst_mem_read", mem_read, 1'b1);
    check("post_rst_addr", mem_address, 32'h0000_7000);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; req0_read = 1'b0;
    tick(); #1;
    check("pre_spur_err", protocol_err, 1'b0);

    // spurious mem_resp while idle
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; #1;
    check("spur_err", protocol_err, 1'b1);
    check("spur_grant", grant, 2'b00);

    // request dropped while granted
    rst = 1'b0; tick(); rst = 1'b1;
    req1_read = 1'b1; req1_address = 32'h0000_8000;
    tick(); #1;
    check("drop_grant", grant, 2'b10);
    req1_read = 1'b0;
    tick(); #1;
    check("drop_err", protocol_err, 1'b1);
    check("drop_grant_held", grant, 2'b10);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; #1;
    check("drop_idle", grant, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Two-requester arbiter sharing the single downstream memory port between the instruction cache (port 0) and data cache (port 1).
- Uses the same read/write/resp handshake as the cache-to-memory side.
- Grants one requester per transaction, holds the grant until mem_resp, then re-arbitrates.
- Sits between the two cache instances and main memory / the bus bridge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- req0_read  in  1  port 0 (I-cache) read request.
- req0_write  in  1  port 0 write request.
- req0_address  in  ADDR_W  port 0 address.
- req0_wdata  in  DATA_W  port 0 write data.
- req0_byte_enable  in  DATA_W/8  port 0 byte enables.
- req0_rdata  out  DATA_W  port 0 read data.
- req0_resp  out  1  port 0 completion pulse.
- req1_read, req1_write, req1_address, req1_wdata, req1_byte_enable, req1_rdata, req1_resp: port 1 (D-cache), same widths, directions and meanings as port 0.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_address  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_byte_enable  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data.
- mem_resp  in  1  memory completion pulse.
- grant  out  2  one-hot current owner; 00 when idle.
- protocol_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=00, last-served pointer=1, protocol_err=0. All mem_* and req*_resp outputs are 0.
- States: IDLE, SERVE0, SERVE1.
- A port is "requesting" when read|write is high.
- IDLE:
  - No requester: stay in IDLE.
  - One requester: go to the matching SERVEn at the next edge.
  - Both requesting: policy per Optional Feature.
- SERVEn:
  - mem_read/write/address/wdata/byte_enable are combinationally muxed from port n. The non-granted port's inputs are ignored.
  - mem_rdata is routed to reqn_rdata. The other port's rdata is 0.
  - reqn_resp = mem_resp, combinational, same cycle.
  - Leave on mem_resp: go to IDLE at the next edge and update the last-served pointer to n.
  - No timeout; the grant is held indefinitely until mem_resp.
- Mandatory IDLE cycle after every completion. Requesters drop read/write the cycle after resp, so a stale request is never regranted.
- Latency:
  - Request seen in IDLE at cycle c: memory request visible at c+1.
  - Minimum request-to-resp: 2 cycles.
  - Back-to-back transactions: 1 dead cycle between them.
- Requester read and write both high:
  - Forwarded as a write only; mem_read=0.
  - Sets protocol_err.
- Requester drops its request while granted, before mem_resp:
  - Sets protocol_err.
  - Arbiter stays in SERVEn until mem_resp.
- mem_resp while IDLE: ignored; sets protocol_err.
- protocol_err clears only on reset.
- Reset mid-transaction: immediate return to IDLE with all outputs low. The in-flight memory transaction is abandoned; the memory side must tolerate this.
- mem_read and mem_write are never both high.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- Defined: round-robin on contention. The port not equal to the last-served pointer wins. Reset pointer=1, so port 0 wins the first contention.
- Undefined: fixed priority; port 1 (D-cache) always wins contention. Port 0 may starve under continuous port 1 traffic.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset then idle: rst low for 3 cycles, then high with no requests -> grant=00, all mem_* outputs 0, protocol_err=0.
- Single read: req0_read=1, address 0x0000_1000 at cycle 0; memory returns 0xDEADBEEF with mem_resp at cycle 4.
  - Expected: grant=01 at cycle 1; mem_address=0x0000_1000 from cycle 1.
  - Expected: req0_resp=1 and req0_rdata=0xDEADBEEF at cycle 4; grant=00 at cycle 5.
- Contention: req0_read and req1_write asserted together, 3 back-to-back rounds, each request re-asserted after its resp.
  - With CACHE_ARB_RR_EN: grant order is 01,10,01,10,...
  - Without it: 10 is granted each time port 1 re-requests.
- Write forwarding: req1_write=1, wdata 0xA5A5_5A5A, byte_enable 0011 -> mem_write=1, mem_wdata and mem_byte_enable match, mem_read=0, req0_resp never asserted.
- Protocol errors:
  - req0 read+write both high -> mem_write=1 only, protocol_err=1 and held through later clean transactions.
  - Spurious mem_resp while IDLE -> protocol_err=1.
- Reset mid-transaction: rst low while in SERVE1 before mem_resp -> grant=00 and mem_write=0 in the same cycle (async). After release, a new req0_read is granted normally.
